axis_dw_downsize: RTL

- Transmit-side AXI4-Stream width converter. Accepts one wide beat of RATIO narrow lanes and emits the kept lanes one per cycle, lowest lane first, on a narrow AXIS master.
- Sits between wide internal datapaths (e.g. output packer) and narrow egress/DMA streams.
- Drop-in stream stage: same clk/rstn/rstn_local scheme as the team's other AXIS stages.

---
 rtl/axis_dw_downsize_if.sv | 15 +
 rtl/axis_dw_downsize.sv | 63 ++++++
 2 files changed

// File: rtl/axis_dw_downsize_if.sv
// axis_dw_downsize_if: AXI4-Stream bundle used on both sides of the width converter.
interface axis_dw_downsize_if #(
   parameter int DATA_WIDTH = 8,
   parameter int KEEP_WIDTH = 1,
   parameter int USER_WIDTH = 1
);
   logic [DATA_WIDTH-1:0] tdata;
   logic [KEEP_WIDTH-1:0] tkeep;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic [USER_WIDTH-1:0] tuser;
   modport master(output tdata, tkeep, tvalid, tlast, tuser, input tready);
   modport slave(input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_dw_downsize.sv
// axis_dw_downsize: splits one wide AXIS beat into its kept narrow lanes, lowest lane first.
module axis_dw_downsize #(
   parameter int M_DATA_WIDTH = 8,
   parameter int RATIO        = 4,
   parameter int S_DATA_WIDTH = M_DATA_WIDTH*RATIO,
   parameter int USER_WIDTH   = 1
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                rstn_local,
   axis_dw_downsize_if.slave   s_axis,
   axis_dw_downsize_if.master  m_axis,
   output logic                drop_pulse
);
   logic [S_DATA_WIDTH-1:0] buf_data;
   logic [RATIO-1:0]        rem_mask, low_oh;
   logic [USER_WIDTH-1:0]   buf_user;
   logic [M_DATA_WIDTH-1:0] lane_mux;
   logic                    buf_last, drop_pulse_reg, single, in_hs, out_hs;
   // two's-complement trick isolates the lowest pending lane
   assign low_oh = rem_mask & (~rem_mask + RATIO'(1));
   assign single = (rem_mask != '0) && ((rem_mask & (rem_mask - RATIO'(1))) == '0);
   always_comb begin
      lane_mux = '0;
      for (int i = 0; i < RATIO; i++)
         lane_mux = lane_mux | (low_oh[i] ? buf_data[i*M_DATA_WIDTH +: M_DATA_WIDTH] : '0);
   end
   assign m_axis.tdata  = lane_mux;
   assign m_axis.tkeep  = '1;
   assign m_axis.tvalid = |rem_mask;
   assign m_axis.tlast  = buf_last && single;
   assign m_axis.tuser  = buf_user;
   // accept the next beat in the same cycle the final lane leaves
   assign s_axis.tready = rstn_local && (rem_mask == '0 || (m_axis.tready && single));
   assign in_hs  = s_axis.tvalid && s_axis.tready;
   assign out_hs = m_axis.tvalid && m_axis.tready;
   assign drop_pulse = drop_pulse_reg;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         buf_data       <= '0;
         rem_mask       <= '0;
         buf_last       <= 1'b0;
         buf_user       <= '0;
         drop_pulse_reg <= 1'b0;
      end else if (!rstn_local) begin
         buf_data       <= '0;
         rem_mask       <= '0;
         buf_last       <= 1'b0;
         buf_user       <= '0;
         drop_pulse_reg <= 1'b0;
      end else begin
         drop_pulse_reg <= in_hs && (s_axis.tkeep == '0);
         if (in_hs) begin
            buf_data <= s_axis.tdata;
            rem_mask <= s_axis.tkeep;
            buf_last <= s_axis.tlast;
            buf_user <= s_axis.tuser;
         end else if (out_hs) begin
            rem_mask <= rem_mask & ~low_oh;
         end
      end
   end
endmodule
